sha256_round_ctrl: RTL and testbench
====================================

// Module: sha256_round_ctrl
// PURPOSE
//  Sequences one SHA-256 compression (64 rounds, one round per clock) over a
//  single shared datapath: majority, choose, Sigma0/1 and a message-schedule window.
//  Accepts a 512-bit block plus a 256-bit chaining value, and returns the 256-bit digest.
//  Sits between the nonce/header feeder and the hash-compare stage of the miner.
// PARAMETERS
//  NUM_ROUNDS  64  rounds per pass (1..64); values below 64 are for debug only
//  CNT_W       7   width of the round counter; must hold NUM_ROUNDS
// PORTS
//  clk         in   1    single clock; all state updates on posedge
//  rst_n       in   1    synchronous, active-low reset
//  in_valid    in   1    block_in/hash_in valid
//  in_ready    out  1    high only in IDLE; accept = in_valid & in_ready
//  block_in    in   512  message block; [511:480] = W0 (big-endian words)
//  hash_in     in   256  chaining value; [255:224] = H0 (a)
//  out_valid   out  1    digest_out valid; held until out_ready
//  out_ready   in   1    consumer accepts; take = out_valid & out_ready
//  digest_out  out  256  final hash; [255:224] = H0
//  busy        out  1    high in ROUND, FINAL or DONE
//  round_o     out  CNT_W  current round index (debug)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, out_valid=0, digest_out=0,
//    round_o=0, a..h=0, W window=0. in_ready=1 from the first cycle after reset.
//  - Reset mid-operation aborts the pass. No output is produced for the aborted block.
//  - FSM states: IDLE -> ROUND -> FINAL -> DONE -> IDLE.
//  - IDLE -> ROUND on accept.
//    * Latch a..h = hash_in and keep hash_in.
//    * Load the W window with block_in.
//    * round_o = 0.
//  - ROUND: each edge performs round t = round_o, then round_o increments.
//    * T1 = h + S1(e) + Ch(e,f,g) + K[t] + W[t]
//    * T2 = S0(a) + Maj(a,b,c)
//    * Maj uses the team's 32-bit majority block.
//    * Register update: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
//    * When t = NUM_ROUNDS-1, the next state is FINAL.
//  - Message schedule: 16-word shift register.
//    * t<16: W[t] = word t of the block.
//    * t>=16: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
//  - Arithmetic: all additions are 32-bit modulo 2^32; carries are discarded.
//  - K[0..63] are the FIPS 180-4 constants, held in an internal case ROM.
//  - FINAL: digest_out = {a..h} + hash_in, word-wise mod 2^32.
//    Sets out_valid=1; state -> DONE.
//  - Latency: accept at edge T; out_valid rises at edge T+NUM_ROUNDS+1 (65 by default).
//  - DONE: digest_out and out_valid are held stable while out_ready=0.
//    On take, out_valid=0 and state -> IDLE. The next accept is possible at the following edge.
//  - in_valid while not IDLE is ignored; there is no queuing.
//  - out_ready while out_valid=0 has no effect.
// CONFIGURATION
//  SHA_DOUBLE_EN defined:
//    * Adds input port dbl_in (1 bit), sampled on accept.
//    * If dbl_in=1, FINAL does not assert out_valid. Instead it starts a second pass with:
//      - block = {first digest, 32'h80000000, 6x32'h0, 32'h00000100}
//      - hash = standard IV 6a09e667..5be0cd19
//    * The second pass then runs ROUND -> FINAL -> DONE as normal.
//    * Total latency = 2*(NUM_ROUNDS+1).
//    * If dbl_in=0, behaviour is identical to the undefined case.
//  SHA_DOUBLE_EN undefined: dbl_in is absent; single pass only.
// TESTING
//  Common setup for tests 1-5: hash_in = IV 6a09e667 bb67ae85 3c6ef372 a54ff53a
//  510e527f 9b05688c 1f83d9ab 5be0cd19.
//  1. "abc": block = 61626380, 14x0, 00000018.
//     -> out_valid at accept+65, digest = ba7816bf 8f01cfea 414140de 5dae2223
//        b00361a3 96177a9c b410ff61 f20015ad.
//  2. Empty message: block = 80000000, 15x0.
//     -> digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
//  3. "abc" with out_ready=0 for 10 cycles after out_valid.
//     -> digest_out and out_valid stable for all 10 cycles; in_ready=0 throughout;
//        IDLE one edge after out_ready=1.
//  4. in_valid pulsed with the empty block at round 20 of an "abc" pass.
//     -> ignored; the "abc" digest is produced; no second out_valid.
//  5. rst_n=0 for 1 cycle at round 30.
//     -> out_valid stays 0, round_o=0, in_ready=1. A following "abc" pass
//        produces the correct digest after 65 cycles.
//  6. SHA_DOUBLE_EN, "abc" block, dbl_in=1.
//     -> out_valid at accept+130, digest = 4f8b42c2 2dd3729b 519ba6f6 8d2da7cc
//        5b2d606d 05daed5a d5128cc0 3e6c6358.

Source files
------------

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: one SHA-256 compression, one round per clock over a shared datapath.
// Optional macro SHA_DOUBLE_EN adds dbl_in to chain a second pass (double SHA-256).
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = 64,
    parameter int CNT_W      = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     block_in,
    input  logic [255:0]     hash_in,
`ifdef SHA_DOUBLE_EN
    input  logic             dbl_in,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [255:0]     digest_out,
    output logic             busy,
    output logic [CNT_W-1:0] round_o
);

    // state   | meaning
    // IDLE    | waiting for a block, in_ready high
    // ROUND   | one compression round per clock, round_q = t
    // FINAL   | add chaining value; publish digest or start second pass
    // DONE    | digest held until out_ready
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    state_t             state_q, state_d;
    logic [31:0]        a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
    logic [31:0]        w_q [16];
    logic [255:0]       hash_q, digest_q, final_sum, st;
    logic [511:0]       load_blk;
    logic [CNT_W-1:0]   round_q;
    logic [5:0]         k_idx;
    logic [31:0]        t1, t2, w_next;
    logic               accept, last_round, chain_q;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        rotr = (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        big_s0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        big_s1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        small_s0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        small_s1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        ch = (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj32(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        maj32 = (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        case (idx)
            6'd0:  k_rom = 32'h428a2f98; 6'd1:  k_rom = 32'h71374491; 6'd2:  k_rom = 32'hb5c0fbcf; 6'd3:  k_rom = 32'he9b5dba5;
            6'd4:  k_rom = 32'h3956c25b; 6'd5:  k_rom = 32'h59f111f1; 6'd6:  k_rom = 32'h923f82a4; 6'd7:  k_rom = 32'hab1c5ed5;
            6'd8:  k_rom = 32'hd807aa98; 6'd9:  k_rom = 32'h12835b01; 6'd10: k_rom = 32'h243185be; 6'd11: k_rom = 32'h550c7dc3;
            6'd12: k_rom = 32'h72be5d74; 6'd13: k_rom = 32'h80deb1fe; 6'd14: k_rom = 32'h9bdc06a7; 6'd15: k_rom = 32'hc19bf174;
            6'd16: k_rom = 32'he49b69c1; 6'd17: k_rom = 32'hefbe4786; 6'd18: k_rom = 32'h0fc19dc6; 6'd19: k_rom = 32'h240ca1cc;
            6'd20: k_rom = 32'h2de92c6f; 6'd21: k_rom = 32'h4a7484aa; 6'd22: k_rom = 32'h5cb0a9dc; 6'd23: k_rom = 32'h76f988da;
            6'd24: k_rom = 32'h983e5152; 6'd25: k_rom = 32'ha831c66d; 6'd26: k_rom = 32'hb00327c8; 6'd27: k_rom = 32'hbf597fc7;
            6'd28: k_rom = 32'hc6e00bf3; 6'd29: k_rom = 32'hd5a79147; 6'd30: k_rom = 32'h06ca6351; 6'd31: k_rom = 32'h14292967;
            6'd32: k_rom = 32'h27b70a85; 6'd33: k_rom = 32'h2e1b2138; 6'd34: k_rom = 32'h4d2c6dfc; 6'd35: k_rom = 32'h53380d13;
            6'd36: k_rom = 32'h650a7354; 6'd37: k_rom = 32'h766a0abb; 6'd38: k_rom = 32'h81c2c92e; 6'd39: k_rom = 32'h92722c85;
            6'd40: k_rom = 32'ha2bfe8a1; 6'd41: k_rom = 32'ha81a664b; 6'd42: k_rom = 32'hc24b8b70; 6'd43: k_rom = 32'hc76c51a3;
            6'd44: k_rom = 32'hd192e819; 6'd45: k_rom = 32'hd6990624; 6'd46: k_rom = 32'hf40e3585; 6'd47: k_rom = 32'h106aa070;
            6'd48: k_rom = 32'h19a4c116; 6'd49: k_rom = 32'h1e376c08; 6'd50: k_rom = 32'h2748774c; 6'd51: k_rom = 32'h34b0bcb5;
            6'd52: k_rom = 32'h391c0cb3; 6'd53: k_rom = 32'h4ed8aa4a; 6'd54: k_rom = 32'h5b9cca4f; 6'd55: k_rom = 32'h682e6ff3;
            6'd56: k_rom = 32'h748f82ee; 6'd57: k_rom = 32'h78a5636f; 6'd58: k_rom = 32'h84c87814; 6'd59: k_rom = 32'h8cc70208;
            6'd60: k_rom = 32'h90befffa; 6'd61: k_rom = 32'ha4506ceb; 6'd62: k_rom = 32'hbef9a3f7; default: k_rom = 32'hc67178f2;
        endcase
    endfunction

    assign accept     = in_valid & in_ready;
    assign last_round = (round_q == CNT_W'(NUM_ROUNDS - 1));
    assign k_idx      = 6'(round_q);
    assign round_o    = round_q;
    assign digest_out = digest_q;

`ifdef SHA_DOUBLE_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                  chain_q <= 1'b0;
        else if (accept)             chain_q <= dbl_in;
        else if (state_q == S_FINAL) chain_q <= 1'b0;
    end
`else
    assign chain_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ROUND;
            S_ROUND: if (last_round) state_d = S_FINAL;
            S_FINAL: state_d = chain_q ? S_ROUND : S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    always_comb begin
        t1     = h_q + big_s1(e_q) + ch(e_q, f_q, g_q) + k_rom(k_idx) + w_q[0];
        t2     = big_s0(a_q) + maj32(a_q, b_q, c_q);
        // window holds W[t..t+15]; the new tail word is W[t+16]
        w_next = small_s1(w_q[14]) + w_q[9] + small_s0(w_q[1]) + w_q[0];
        st     = {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
        final_sum = '0;
        for (int i = 0; i < 8; i++)
            final_sum[255-32*i -: 32] = st[255-32*i -: 32] + hash_q[255-32*i -: 32];
        load_blk = (state_q == S_FINAL) ? {final_sum, 32'h80000000, 192'h0, 32'h00000100} : block_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= '0;
            hash_q   <= '0;
            digest_q <= '0;
            round_q  <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= hash_in;
                    hash_q  <= hash_in;
                    round_q <= '0;
                    for (int i = 0; i < 16; i++) w_q[i] <= load_blk[511-32*i -: 32];
                end
                S_ROUND: begin
                    h_q <= g_q;
                    g_q <= f_q;
                    f_q <= e_q;
                    e_q <= d_q + t1;
                    d_q <= c_q;
                    c_q <= b_q;
                    b_q <= a_q;
                    a_q <= t1 + t2;
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                    w_q[15] <= w_next;
                    round_q <= round_q + CNT_W'(1);
                end
                S_FINAL: if (chain_q) begin
                    {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= IV;
                    hash_q  <= IV;
                    round_q <= '0;
                    for (int i = 0; i < 16; i++) w_q[i] <= load_blk[511-32*i -: 32];
                end else begin
                    digest_q <= final_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: known SHA-256 vectors, back-pressure, ignored input, mid-pass reset.
module tb_sha256_round_ctrl;

    localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMP = {32'h80000000, 480'h0};
    localparam logic [255:0] DG_ABC  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DG_EMP  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DG_DBL  = 256'h4f8b42c2_2dd3729b_519ba6f6_8d2da7cc_5b2d606d_05daed5a_d5128cc0_3e6c6358;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] block_in;
    logic [255:0] hash_in;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] digest_out;
    logic         busy;
    logic [6:0]   round_o;
`ifdef SHA_DOUBLE_EN
    logic         dbl_r;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int lat;
    int seen;
    logic [255:0] held;

    sha256_round_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .block_in   (block_in),
        .hash_in    (hash_in),
`ifdef SHA_DOUBLE_EN
        .dbl_in     (dbl_r),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .digest_out (digest_out),
        .busy       (busy),
        .round_o    (round_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [511:0] blk);
        block_in = blk;
        hash_in  = IV;
        in_valid = 1'b1;
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int l);
        int n = 0;
        while (!out_valid && n < limit) begin
            tick();
            n++;
        end
        l = out_valid ? (cyc - acc_cyc) : -1;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        block_in = '0; hash_in = '0;
`ifdef SHA_DOUBLE_EN
        dbl_r = 1'b0;
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_digest",    digest_out, 0);
        chk("rst_round",     round_o, 0);
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_busy",      busy, 0);

        // 1: "abc"
        send(BLK_ABC);
        chk("t1_busy", busy, 1);
        chk("t1_in_ready", in_ready, 0);
        wait_valid(200, lat);
        chk("t1_latency", lat, 65);
        chk("t1_digest", digest_out, DG_ABC);
        take();
        chk("t1_taken_valid", out_valid, 0);
        chk("t1_taken_ready", in_ready, 1);

        // 2: empty message
        send(BLK_EMP);
        wait_valid(200, lat);
        chk("t2_latency", lat, 65);
        chk("t2_digest", digest_out, DG_EMP);
        take();

        // 3: back-pressure for 10 cycles
        send(BLK_ABC);
        wait_valid(200, lat);
        chk("t3_latency", lat, 65);
        held = digest_out;
        chk("t3_digest", held, DG_ABC);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_digest", digest_out, DG_ABC);
            chk("t3_hold_in_ready", in_ready, 0);
        end
        take();
        chk("t3_idle_valid", out_valid, 0);
        chk("t3_idle_in_ready", in_ready, 1);
        chk("t3_idle_busy", busy, 0);

        // 4: in_valid pulse mid-pass is ignored
        send(BLK_ABC);
        repeat (20) tick();
        chk("t4_round20", round_o, 20);
        block_in = BLK_EMP;
        in_valid = 1'b1;
        chk("t4_in_ready_busy", in_ready, 0);
        tick();
        in_valid = 1'b0;
        wait_valid(200, lat);
        chk("t4_latency", lat, 65);
        chk("t4_digest", digest_out, DG_ABC);
        take();
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("t4_no_second", seen, 0);

        // 5: reset at round 30 aborts the pass
        send(BLK_ABC);
        repeat (30) tick();
        chk("t5_round30", round_o, 30);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_valid", out_valid, 0);
        chk("t5_round", round_o, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("t5_no_output", seen, 0);
        send(BLK_ABC);
        wait_valid(200, lat);
        chk("t5_latency", lat, 65);
        chk("t5_digest", digest_out, DG_ABC);
        take();

`ifdef SHA_DOUBLE_EN
        // 6: double SHA-256 of "abc"
        dbl_r = 1'b1;
        send(BLK_ABC);
        dbl_r = 1'b0;
        wait_valid(400, lat);
        chk("t6_latency", lat, 130);
        chk("t6_digest", digest_out, DG_DBL);
        take();
        chk("t6_idle", in_ready, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
